data_memory_bytelane: RTL and testbench

Parametrised byte-addressable data memory for the single-cycle RISC-V datapath, replacing the word-only data memory. It supports RV32I load/store widths (byte, half, word; signed and unsigned loads) with little-endian byte lanes, and flags misaligned and out-of-range accesses. Reset clears the array with a multi-cycle sweep engine instead of a one-cycle loop; `busy` tells the core to stall until the clear finishes.

---
 rtl/data_memory_bytelane.sv | 125 ++++++++++++
 tb/tb_data_memory_bytelane.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory with RV32I load/store widths and little-endian lanes.
// Reset starts a one-word-per-cycle clear sweep; busy_o stalls the core until it finishes.
module data_memory_bytelane #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    input  logic [2:0]      funct3_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            out_of_range_o,
    output logic            busy_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned NL = XLEN / 8;
    localparam logic [IW-1:0] IdxLast = IW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e          state_q;
    logic [IW-1:0]   clr_idx_q;
    logic            busy_q;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic [IW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            access;
    logic            mis_raw;
    logic            oor_raw;
    logic            ok;
    logic [NL-1:0]   wr_be;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    assign word_idx = addr_i[IW+1:2];
    assign lane     = addr_i[1:0];
    assign access   = !busy_q && (mem_rd_i || mem_wr_i);
    assign mis_raw  = ((funct3_i[1:0] == 2'b01) && lane[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (lane != 2'b00));
    assign oor_raw  = |addr_i[AW-1:IW+2];
    assign ok       = !busy_q && !mis_raw && !oor_raw;

    assign misaligned_o   = access && mis_raw;
    assign out_of_range_o = access && oor_raw;
    assign busy_o         = busy_q;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        wr_be   = '0;
        wr_data = wdata_i;
        case (funct3_i)
            3'b000: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {NL{wdata_i[7:0]}};
            end
            3'b001: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {(NL / 2){wdata_i[15:0]}};
            end
            3'b010:  wr_be = '1;
            default: wr_be = '0;
        endcase
        if (!(mem_wr_i && ok)) begin
            wr_be = '0;
        end
    end

    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rdata_o = '0;
        if (mem_rd_i && ok) begin
            case (funct3_i)
                3'b000:  rdata_o = {{(XLEN - 8){rd_byte[7]}}, rd_byte};
                3'b001:  rdata_o = {{(XLEN - 16){rd_half[15]}}, rd_half};
                3'b010:  rdata_o = rd_word;
                3'b100:  rdata_o = {{(XLEN - 8){1'b0}}, rd_byte};
                3'b101:  rdata_o = {{(XLEN - 16){1'b0}}, rd_half};
                default: rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                StClear: begin
                    mem_q[clr_idx_q] <= '0;
                    clr_idx_q        <= clr_idx_q + IW'(1);
                    if (clr_idx_q == IdxLast) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    for (int i = 0; i < NL; i++) begin
                        if (wr_be[i]) begin
                            mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                        end
                    end
                end
                default: begin
                    state_q <= StClear;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane (DEPTH=16): directed steps plus random accesses
// checked against a byte-array reference model.
module tb_data_memory_bytelane;

    localparam int unsigned Depth = 16;
    localparam int unsigned Bytes = Depth * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        mis;
    logic        oor;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [7:0]  m [Bytes];
    logic [31:0] last_rd;
    logic        last_mis;
    logic        last_oor;

    always #5 clk = ~clk;

    data_memory_bytelane #(
        .XLEN (32),
        .DEPTH(Depth),
        .AW   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_i      (mem_rd),
        .mem_wr_i      (mem_wr),
        .funct3_i      (f3),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rdata_o       (rdata),
        .misaligned_o  (mis),
        .out_of_range_o(oor),
        .busy_o        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic mis_of(input logic [2:0] fn, input logic [31:0] a);
        return ((fn[1:0] == 2'b01) && (a % 2 != 0)) || ((fn[1:0] == 2'b10) && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] a);
        int i;
        if (a >= Bytes || mis_of(fn, a)) return 32'd0;
        i = int'(a);
        case (fn)
            3'd0:    return 32'(int'($signed(m[i])));
            3'd1:    return 32'(int'($signed({m[i+1], m[i]})));
            3'd2:    return {m[i+3], m[i+2], m[i+1], m[i]};
            3'd4:    return 32'(m[i]);
            3'd5:    return 32'({m[i+1], m[i]});
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
        int n;
        if (a >= Bytes || mis_of(fn, a)) return;
        case (fn)
            3'd0:    n = 1;
            3'd1:    n = 2;
            3'd2:    n = 4;
            default: n = 0;
        endcase
        for (int k = 0; k < n; k++) m[int'(a) + k] = wd[8*k +: 8];
    endtask

    // Drive one access, check combinational outputs, take the edge, then update the model.
    task automatic access(input logic rd, input logic wr, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] er;
        logic        em;
        logic        eo;
        mem_rd = rd;
        mem_wr = wr;
        f3 = fn;
        addr = a;
        wdata = wd;
        #1;
        er = rd ? ref_load(fn, a) : 32'd0;
        em = (rd || wr) && mis_of(fn, a);
        eo = (rd || wr) && (a >= Bytes);
        last_rd = rdata;
        last_mis = mis;
        last_oor = oor;
        check({tag, ".rdata"}, rdata, er);
        check({tag, ".mis"}, 32'(mis), 32'(em));
        check({tag, ".oor"}, 32'(oor), 32'(eo));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        if (wr) ref_store(fn, a, wd);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    // Entered just after rst falls; counts edges until busy drops.
    task automatic wait_sweep(input string tag, input bit inject);
        int n = 0;
        while (n < 64 && busy === 1'b1) begin
            if (inject && n == 10) begin
                mem_rd = 1'b1; f3 = 3'd2; addr = 32'h41;
                #1;
                check({tag, ".busy_rdata"}, rdata, 32'd0);
                check({tag, ".busy_mis"}, 32'(mis), 32'd0);
                check({tag, ".busy_oor"}, 32'(oor), 32'd0);
            end
            if (inject && n == 12) begin
                mem_rd = 1'b1; mem_wr = 1'b1; f3 = 3'd2; addr = 32'h0; wdata = 32'hDEADBEEF;
                #1;
                check({tag, ".busy_store_rdata"}, rdata, 32'd0);
            end
            @(posedge clk);
            #1;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            n++;
        end
        check({tag, ".edges"}, 32'(n), 32'd16);
        for (int i = 0; i < int'(Bytes); i++) m[i] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_rd = 1'b1; mem_wr = 1'b1; f3 = 3'd1; addr = 32'h43; wdata = 32'hFFFF;
        #1;
        check("reset.busy", 32'(busy), 32'd1);
        check("reset.rdata", rdata, 32'd0);
        check("reset.mis", 32'(mis), 32'd0);
        check("reset.oor", 32'(oor), 32'd0);
        mem_rd = 1'b0; mem_wr = 1'b0;
        rst = 1'b0;
        wait_sweep("sweep0", 1'b0);

        for (int w = 0; w < int'(Depth); w++)
            access(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom | 32'h1, "preload");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sweep("sweep1", 1'b1);
        for (int w = 0; w < int'(Depth); w++) begin
            access(1'b1, 1'b0, 3'd2, 32'(w * 4), 32'd0, "cleared");
            check("cleared.const", last_rd, 32'd0);
        end

        access(1'b0, 1'b1, 3'd2, 32'h8, 32'h80F17F22, "sw8");
        access(1'b1, 1'b0, 3'd0, 32'h8, 32'd0, "lb8");
        check("lb8.const", last_rd, 32'h00000022);
        access(1'b1, 1'b0, 3'd0, 32'hB, 32'd0, "lbB");
        check("lbB.const", last_rd, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'd4, 32'hB, 32'd0, "lbuB");
        check("lbuB.const", last_rd, 32'h00000080);
        access(1'b1, 1'b0, 3'd1, 32'hA, 32'd0, "lhA");
        check("lhA.const", last_rd, 32'hFFFF80F1);
        access(1'b1, 1'b0, 3'd5, 32'hA, 32'd0, "lhuA");
        check("lhuA.const", last_rd, 32'h000080F1);

        access(1'b0, 1'b1, 3'd2, 32'h4, 32'h0, "sw4");
        access(1'b0, 1'b1, 3'd0, 32'h5, 32'hAB, "sb5");
        access(1'b0, 1'b1, 3'd1, 32'h6, 32'h1234, "sh6");
        access(1'b1, 1'b0, 3'd2, 32'h4, 32'd0, "lw4");
        check("lw4.const", last_rd, 32'h1234AB00);

        access(1'b0, 1'b1, 3'd1, 32'h3, 32'hBEEF, "sh3");
        check("sh3.mis_const", 32'(last_mis), 32'd1);
        access(1'b1, 1'b0, 3'd2, 32'h0, 32'd0, "lw0_after_sh3");
        check("lw0_after_sh3.const", last_rd, 32'd0);
        access(1'b1, 1'b0, 3'd2, 32'h2, 32'd0, "lw2");
        check("lw2.mis_const", 32'(last_mis), 32'd1);
        check("lw2.rdata_const", last_rd, 32'd0);
        access(1'b1, 1'b0, 3'd0, 32'h3, 32'd0, "lb3");
        check("lb3.mis_const", 32'(last_mis), 32'd0);

        access(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, "sw40");
        check("sw40.oor_const", 32'(last_oor), 32'd1);
        for (int w = 0; w < int'(Depth); w++)
            access(1'b1, 1'b0, 3'd2, 32'(w * 4), 32'd0, "after_oor");
        access(1'b1, 1'b0, 3'd2, 32'h3C, 32'd0, "lw3C");
        check("lw3C.oor_const", 32'(last_oor), 32'd0);

        for (int i = 0; i < 300; i++)
            access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 79)), $urandom, "rand");

        access(1'b0, 1'b1, 3'd2, 32'h0, 32'h11, "sw11");
        access(1'b1, 1'b1, 3'd2, 32'h0, 32'h55, "rmw");
        check("rmw.old", last_rd, 32'h11);
        access(1'b1, 1'b0, 3'd2, 32'h0, 32'd0, "rmw_new");
        check("rmw_new.const", last_rd, 32'h55);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midsweep.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sweep("sweep2", 1'b0);
        for (int w = 0; w < int'(Depth); w++)
            access(1'b1, 1'b0, 3'd2, 32'(w * 4), 32'd0, "sweep2_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
